// File: rtl/priscv_pkg.sv
// rtl/priscv_pkg.sv - shared constants, enums, pipeline record and helpers for the PRISCV core
package priscv_pkg;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  // An all-zero record is a bubble: no side effects and pc = 0.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
  } id_ex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_type_e t);
    case (t)
      IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_gen = {i[31:12], 12'h000};
      IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // Immediate forms never subtract; bit 30 of an ADDI is just immediate data.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_imm);
    case (f3)
      F3_ADD:  alu_decode = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_decode = ALU_SLL;
      F3_SLT:  alu_decode = ALU_SLT;
      F3_SLTU: alu_decode = ALU_SLTU;
      F3_XOR:  alu_decode = ALU_XOR;
      F3_SR:   alu_decode = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:   alu_exec = a - b;
      ALU_SLL:   alu_exec = a << b[4:0];
      ALU_SLT:   alu_exec = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  alu_exec = {31'd0, a < b};
      ALU_XOR:   alu_exec = a ^ b;
      ALU_SRL:   alu_exec = a >> b[4:0];
      ALU_SRA:   alu_exec = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    alu_exec = a | b;
      ALU_AND:   alu_exec = a & b;
      ALU_PASSB: alu_exec = b;
      default:   alu_exec = a + b;
    endcase
  endfunction
endpackage

// File: rtl/priscv_core.sv
// rtl/priscv_core.sv - five-stage RV32I-subset pipeline with forwarding, load-use stall and EX redirect
module priscv_core #(
  parameter logic [31:0] RESET_PC = priscv_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);
  import priscv_pkg::*;

  logic [31:0] pc, if_id_instr, if_id_pc;
  id_ex_t      id_dec, id_ex;
  logic [31:0] ex_mem_pc, ex_mem_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [31:0] mem_wb_io_data_pc, mem_wb_wdata;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic [31:0] rdata1, rdata2, fwd_a, fwd_b, ex_result, target;
  logic [6:0]  opcode;
  imm_type_e   imm_type;
  logic        use_rs1, use_rs2, stall, taken, redirect, alt;

  priscv_regfile regs (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (if_id_instr[19:15]),
    .raddr2 (if_id_instr[24:20]),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (mem_wb_reg_write),
    .waddr  (mem_wb_rd),
    .wdata  (mem_wb_wdata)
  );

  assign opcode = if_id_instr[6:0];
  assign alt    = (if_id_instr[31:25] == F7_ALT);

  always_comb begin
    id_dec         = '0;
    imm_type       = IMM_I;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    id_dec.pc      = if_id_pc;
    id_dec.rs1     = if_id_instr[19:15];
    id_dec.rs2     = if_id_instr[24:20];
    id_dec.rd      = if_id_instr[11:7];
    id_dec.funct3  = if_id_instr[14:12];
    id_dec.rs1_val = rdata1;
    id_dec.rs2_val = rdata2;
    case (opcode)
      OP_LUI:    begin id_dec.reg_write = 1'b1; id_dec.src_b_imm = 1'b1; id_dec.alu_op = ALU_PASSB; imm_type = IMM_U; end
      OP_AUIPC:  begin id_dec.reg_write = 1'b1; id_dec.src_a_pc = 1'b1; id_dec.src_b_imm = 1'b1; imm_type = IMM_U; end
      OP_JAL:    begin id_dec.reg_write = 1'b1; id_dec.jal = 1'b1; imm_type = IMM_J; end
      OP_JALR:   begin id_dec.reg_write = 1'b1; id_dec.jalr = 1'b1; use_rs1 = 1'b1; end
      OP_BRANCH: begin id_dec.branch = 1'b1; imm_type = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LOAD:   begin id_dec.reg_write = 1'b1; id_dec.mem_read = 1'b1; id_dec.src_b_imm = 1'b1; use_rs1 = 1'b1; end
      OP_STORE:  begin id_dec.mem_write = 1'b1; id_dec.src_b_imm = 1'b1; imm_type = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM:    begin id_dec.reg_write = 1'b1; id_dec.src_b_imm = 1'b1; use_rs1 = 1'b1;
                       id_dec.alu_op = alu_decode(if_id_instr[14:12], alt, 1'b1); end
      OP_REG:    begin id_dec.reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                       id_dec.alu_op = alu_decode(if_id_instr[14:12], alt, 1'b0); end
      default:   ;
    endcase
    id_dec.imm = imm_gen(if_id_instr, imm_type);
  end

  assign stall = id_ex.mem_read && id_ex.rd != 5'd0 &&
                 ((use_rs1 && id_ex.rd == if_id_instr[19:15]) ||
                  (use_rs2 && id_ex.rd == if_id_instr[24:20]));

  // Later assignment wins, so EX/MEM takes priority over MEM/WB.
  always_comb begin
    fwd_a = id_ex.rs1_val;
    fwd_b = id_ex.rs2_val;
    if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex.rs1) fwd_a = mem_wb_wdata;
    if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex.rs2) fwd_b = mem_wb_wdata;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex.rs1) fwd_a = ex_mem_result;
    if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex.rs2) fwd_b = ex_mem_result;
    case (id_ex.funct3)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a < fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
    redirect  = id_ex.jal || id_ex.jalr || (id_ex.branch && taken);
    target    = id_ex.jalr ? ((fwd_a + id_ex.imm) & ~32'd1) : (id_ex.pc + id_ex.imm);
    ex_result = (id_ex.jal || id_ex.jalr) ? (id_ex.pc + 32'd4) :
                alu_exec(id_ex.alu_op, id_ex.src_a_pc ? id_ex.pc : fwd_a,
                         id_ex.src_b_imm ? id_ex.imm : fwd_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                <= RESET_PC;
      if_id_instr       <= NOP_INSTR;
      if_id_pc          <= '0;
      id_ex             <= '0;
      ex_mem_pc         <= '0;
      ex_mem_result     <= '0;
      ex_mem_store_data <= '0;
      ex_mem_rd         <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      mem_wb_io_data_pc <= '0;
      mem_wb_wdata      <= '0;
      mem_wb_rd         <= '0;
      mem_wb_reg_write  <= 1'b0;
    end else begin
      if (redirect) begin
        pc          <= target;
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
      end else if (!stall) begin
        pc          <= pc + 32'd4;
        if_id_instr <= imem_instr;
        if_id_pc    <= pc;
      end
      if (redirect || stall) id_ex <= '0;
      else                   id_ex <= id_dec;
      ex_mem_pc         <= id_ex.pc;
      ex_mem_result     <= ex_result;
      ex_mem_store_data <= fwd_b;
      ex_mem_rd         <= id_ex.rd;
      ex_mem_reg_write  <= id_ex.reg_write;
      ex_mem_mem_read   <= id_ex.mem_read;
      ex_mem_mem_write  <= id_ex.mem_write;
      mem_wb_io_data_pc <= ex_mem_pc;
      mem_wb_wdata      <= ex_mem_mem_read ? dmem_rdata : ex_mem_result;
      mem_wb_rd         <= ex_mem_rd;
      mem_wb_reg_write  <= ex_mem_reg_write;
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = ex_mem_result;
  assign dmem_wdata = ex_mem_store_data;
  assign dmem_we    = ex_mem_mem_write;
endmodule

// File: rtl/priscv_dmem.sv
// rtl/priscv_dmem.sv - word-addressed data RAM, combinational read, synchronous write
module priscv_dmem #(
  parameter int DM_WORDS = 256
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DM_WORDS);

  logic [31:0] DMEM [0:DM_WORDS-1];
  logic        addr_unused;

  assign addr_unused = ^{addr[31:AW+2], addr[1:0]};
  assign rdata = DMEM[addr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (we) DMEM[addr[AW+1:2]] <= wdata;
  end
endmodule

// File: rtl/priscv_imem.sv
// rtl/priscv_imem.sv - word-addressed instruction ROM, combinational read, loaded from outside
module priscv_imem #(
  parameter int IM_WORDS = 256
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int AW = $clog2(IM_WORDS);

  logic [31:0] IMEM [0:IM_WORDS-1];
  logic        addr_unused;

  assign addr_unused = ^{addr[31:AW+2], addr[1:0]};
  assign instr = IMEM[addr[AW+1:2]];
endmodule

// File: rtl/priscv_regfile.sv
// rtl/priscv_regfile.sv - 32x32 register file, x0 hardwired, WB write visible to same-cycle reads
module priscv_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/priscv_top.sv
// rtl/priscv_top.sv - PRISCV top: core plus instruction ROM and data RAM
module priscv_top #(
  parameter int          IM_WORDS = 256,
  parameter int          DM_WORDS = 256,
  parameter logic [31:0] RESET_PC = priscv_pkg::RESET_PC
) (
  input  logic clk,
  input  logic reset
);
  logic [31:0] imem_addr;
  logic [31:0] io_imem_instr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_we;

  priscv_core #(.RESET_PC(RESET_PC)) U_CPU (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (io_imem_instr),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata)
  );

  priscv_imem #(.IM_WORDS(IM_WORDS)) U_IM (
    .addr  (imem_addr),
    .instr (io_imem_instr)
  );

  priscv_dmem #(.DM_WORDS(DM_WORDS)) U_DM (
    .clk   (clk),
    .addr  (dmem_addr),
    .wdata (dmem_wdata),
    .we    (dmem_we),
    .rdata (dmem_rdata)
  );
endmodule

// File: tb/tb_priscv_top.sv
// tb/tb_priscv_top.sv - directed program bench for priscv_top: retirement trace, registers, memory
module tb_priscv_top;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] prog   [0:18];
  logic [31:0] exp_wb [1:27];

  priscv_top dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    prog[0]  = 32'h00500093;  // 0x00 addi x1,x0,5
    prog[1]  = 32'h00308113;  // 0x04 addi x2,x1,3
    prog[2]  = 32'h002081B3;  // 0x08 add  x3,x1,x2
    prog[3]  = 32'h00302023;  // 0x0C sw   x3,0(x0)
    prog[4]  = 32'h00002203;  // 0x10 lw   x4,0(x0)
    prog[5]  = 32'h00120293;  // 0x14 addi x5,x4,1
    prog[6]  = 32'h00700013;  // 0x18 addi x0,x0,7
    prog[7]  = 32'h800003B7;  // 0x1C lui  x7,0x80000
    prog[8]  = 32'h008000EF;  // 0x20 jal  x1,+8
    prog[9]  = 32'h0100006F;  // 0x24 jal  x0,+16
    prog[10] = 32'h00008067;  // 0x28 jalr x0,0(x1)
    prog[11] = 32'h00000013;  // 0x2C nop
    prog[12] = 32'h00000013;  // 0x30 nop
    prog[13] = 32'h00000663;  // 0x34 beq  x0,x0,+12
    prog[14] = 32'h00100313;  // 0x38 addi x6,x0,1
    prog[15] = 32'h00200313;  // 0x3C addi x6,x0,2
    prog[16] = 32'h41F3D413;  // 0x40 srai x8,x7,31
    prog[17] = 32'h007034B3;  // 0x44 sltu x9,x0,x7
    prog[18] = 32'h0000006F;  // 0x48 jal  x0,0
    for (int i = 0; i < 256; i++) dut.U_IM.IMEM[i] = 32'h00000013;
    for (int i = 0; i < 19; i++) dut.U_IM.IMEM[i] = prog[i];

    exp_wb[1]  = 32'h00; exp_wb[2]  = 32'h00; exp_wb[3]  = 32'h00; exp_wb[4]  = 32'h00;
    exp_wb[5]  = 32'h04; exp_wb[6]  = 32'h08; exp_wb[7]  = 32'h0C; exp_wb[8]  = 32'h10;
    exp_wb[9]  = 32'h00; exp_wb[10] = 32'h14; exp_wb[11] = 32'h18; exp_wb[12] = 32'h1C;
    exp_wb[13] = 32'h20; exp_wb[14] = 32'h00; exp_wb[15] = 32'h00; exp_wb[16] = 32'h28;
    exp_wb[17] = 32'h00; exp_wb[18] = 32'h00; exp_wb[19] = 32'h24; exp_wb[20] = 32'h00;
    exp_wb[21] = 32'h00; exp_wb[22] = 32'h34; exp_wb[23] = 32'h00; exp_wb[24] = 32'h00;
    exp_wb[25] = 32'h40; exp_wb[26] = 32'h44; exp_wb[27] = 32'h48;

    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_pc", dut.U_CPU.pc, 32'h0);
    check("reset_wb_pc", dut.U_CPU.mem_wb_io_data_pc, 32'h0);
    check("reset_x1", dut.U_CPU.regs.regs[1], 32'h0);
    check("fetch_instr_pc0", dut.io_imem_instr, 32'h00500093);

    for (int t = 1; t <= 27; t++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("wb_pc_t%0d", t), dut.U_CPU.mem_wb_io_data_pc, exp_wb[t]);
      if (t == 1) check("pc_t1", dut.U_CPU.pc, 32'h04);
      if (t == 2) check("pc_t2", dut.U_CPU.pc, 32'h08);
      if (t == 3) check("pc_t3", dut.U_CPU.pc, 32'h0C);
      if (t == 4) check("x1_before_wb_write", dut.U_CPU.regs.regs[1], 32'h0);
      if (t == 5) check("x1_after_wb_write", dut.U_CPU.regs.regs[1], 32'h5);
      if (t == 6) check("pc_t6", dut.U_CPU.pc, 32'h18);
      if (t == 7) check("pc_held_by_load_use", dut.U_CPU.pc, 32'h18);
      if (t == 12) check("pc_after_jal", dut.U_CPU.pc, 32'h28);
      if (t == 15) check("pc_after_jalr", dut.U_CPU.pc, 32'h24);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("x0", dut.U_CPU.regs.regs[0], 32'h0);
    check("x1_link", dut.U_CPU.regs.regs[1], 32'h24);
    check("x2_fwd", dut.U_CPU.regs.regs[2], 32'h8);
    check("x3_fwd", dut.U_CPU.regs.regs[3], 32'd13);
    check("x4_load", dut.U_CPU.regs.regs[4], 32'd13);
    check("x5_load_use", dut.U_CPU.regs.regs[5], 32'd14);
    check("x6_flushed", dut.U_CPU.regs.regs[6], 32'h0);
    check("x7_lui", dut.U_CPU.regs.regs[7], 32'h80000000);
    check("x8_srai", dut.U_CPU.regs.regs[8], 32'hFFFFFFFF);
    check("x9_sltu", dut.U_CPU.regs.regs[9], 32'h1);
    check("dmem0_store", dut.U_DM.DMEM[0], 32'd13);

    reset = 1'b1;
    #1;
    check("async_reset_pc", dut.U_CPU.pc, 32'h0);
    check("async_reset_x8", dut.U_CPU.regs.regs[8], 32'h0);
    check("async_reset_dmem_kept", dut.U_DM.DMEM[0], 32'd13);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/priscv_top.md
Name: priscv_top

Overview:
- Top-level of the PRISCV RV32I integer subset processor.
- Contains a five-stage pipelined core (U_CPU), a word-addressed instruction ROM (U_IM) and a word-addressed data RAM (U_DM).
- Has no functional outputs. Benches observe it through fixed hierarchical names and load the program with $readmemh into U_IM.IMEM.

Parameters:
- IM_WORDS, 256, depth of instruction memory in 32-bit words (index = pc[9:2]).
- DM_WORDS, 256, depth of data memory in 32-bit words (index = addr[9:2]).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.

Behaviour:
- Mandatory hierarchy, all names exact:
  - U_IM.IMEM: reg [31:0] [0:IM_WORDS-1].
  - U_DM.DMEM: reg [31:0] [0:DM_WORDS-1].
  - U_CPU.pc: 32-bit IF-stage PC.
  - U_CPU.mem_wb_io_data_pc: 32-bit PC held in the MEM/WB register.
  - U_CPU.regs.regs: reg [31:0] [0:31].
  - Top-level wire io_imem_instr = U_IM.IMEM[U_CPU.pc[9:2]].
- Reset (asynchronous):
  - pc = RESET_PC.
  - All pipeline registers become bubbles (NOP, pc field 0).
  - regs[0..31] = 0.
  - IMEM and DMEM are not reset.
- Instruction memory: combinational read, no write port.
- Data memory: combinational read; synchronous word write on the rising edge when the MEM-stage store is valid.
- Supported ISA:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Any other opcode executes as a NOP.
- Pipeline stages: IF, ID (register read, immediate generation), EX (ALU, branch compare, target compute), MEM, WB.
- Register file: writes in WB on the rising edge; reads in ID.
- Register file write-before-read bypass: a WB write is visible to an ID read in the same cycle.
- x0 reads as 0 and writes to x0 are discarded.
- Forwarding into EX operands, priority EX/MEM over MEM/WB; never forward from destination x0.
- Load-use hazard (LW in EX, dependent instruction in ID): stall PC and IF/ID for 1 cycle and insert a bubble into ID/EX.
- Control transfers:
  - Branches and jumps resolve in EX.
  - Taken branch/JAL/JALR: flush IF/ID and ID/EX (2 bubbles); pc takes the target next cycle.
  - JALR target = (rs1 + imm) & ~1.
  - JAL/JALR write pc+4 to rd.
  - Not-taken branches: no penalty.
- Bubbles carry pc = 0 through every stage, so mem_wb_io_data_pc = 0 marks an empty WB slot.
- Arithmetic: 32-bit wraparound; shift amount = operand[4:0]; SLT is signed, SLTU is unsigned.
- Misaligned or out-of-range addresses: the low 2 bits and the bits above [9:2] are ignored (wrap modulo memory depth).
- Reset mid-operation: in-flight stores are abandoned. A store already committed to DMEM stays.

Decomposition:
- Shared package priscv_pkg holds:
  - opcode constants;
  - funct3/funct7 constants;
  - ALU op enum;
  - immediate-type enum;
  - RESET_PC;
  - NOP encoding (32'h0000_0013).
- Sub-modules:
  - U_CPU (priscv_core), with the register file instance named regs (priscv_regfile).
  - U_IM (priscv_imem).
  - U_DM (priscv_dmem).
- The register file is the one natural leaf sub-module inside the core.

Test Plan:
- Reset and fetch:
  - Stimulus: reset high for 1 cycle, then release; IMEM[0]=32'h00500093 (addi x1,x0,5).
  - Required: pc steps 0,4,8,…; io_imem_instr = 32'h00500093 while pc = 0.
  - Required: regs[1] = 5 once the instruction reaches WB (4 cycles after its fetch).
- Forwarding:
  - Stimulus: addi x1,x0,5; addi x2,x1,3; add x3,x1,x2 issued back-to-back.
  - Required: x2 = 8, x3 = 13, with no stall cycles.
- Load-use:
  - Stimulus: sw x3,0(x0); lw x4,0(x0); addi x5,x4,1.
  - Required: DMEM[0] = 13, x5 = 14.
  - Required: exactly one bubble, seen as mem_wb_io_data_pc = 0 for one cycle between the lw and addi retirements.
- Branch flush:
  - Stimulus: beq x0,x0,+12, followed by two addi x6 instructions.
  - Required: x6 stays 0; the next retired PC after the beq is beq_pc+12; 2 bubbles retire.
- Jumps:
  - Stimulus: jal x1,+8 at pc 0x20.
  - Required: x1 = 0x24; fetch resumes at 0x28.
  - Stimulus: jalr x0,0(x1).
  - Required: returns to 0x24.
- x0 and arithmetic edge cases:
  - Stimulus: addi x0,x0,7.
  - Required: regs[0] stays 0.
  - Stimulus: lui x7,0x80000; srai x8,x7,31; sltu x9,x0,x7.
  - Required: x8 = 32'hFFFFFFFF, x9 = 1.
